// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// fetch_pkg: widths, reset vector, FSM state encoding and buffer entry type
// shared by the instruction fetch stage.
package fetch_pkg;

  localparam int WORD_SIZE    = 10;
  localparam int ADDRESS_SIZE = 8;

  localparam logic [ADDRESS_SIZE-1:0] RESET_VECTOR = 8'h00;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IDLE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0]    word;
  } fetch_entry_t;

  // Sequential successor; wraps from the top of program memory back to 0.
  function automatic logic [ADDRESS_SIZE-1:0] pc_next(input logic [ADDRESS_SIZE-1:0] pc);
    return pc + ADDRESS_SIZE'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// instr_fetch_unit_if: program-memory read port, branch redirect and
// ready/valid instruction hand-off between fetch and the rest of the core.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE,
  parameter int ADDR_W = ADDRESS_SIZE
) ();

  logic              run;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [DATA_W-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    input  run,
    input  mem_data,
    input  redirect,
    input  redirect_pc,
    input  instr_ready,
    output mem_address,
    output mem_read,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output run,
    output mem_data,
    output redirect,
    output redirect_pc,
    output instr_ready,
    input  mem_address,
    input  mem_read,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_buffer.sv
`default_nettype none
// fetch_buffer: synchronous FIFO of fetched {pc, word} entries; flush wins
// over push, and push into a full buffer is accepted only alongside a pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  if (DEPTH < 2) begin : g_depth_check
    $error("fetch_buffer: DEPTH must be at least 2");
  end

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: program counter, boot/run/idle sequencing and read issue
// into a one-cycle-latency program memory, buffered into a ready/valid stream.
module instr_fetch_unit #(
  parameter int word_size    = fetch_pkg::WORD_SIZE,
  parameter int address_size = fetch_pkg::ADDRESS_SIZE,
  parameter logic [address_size-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter int DEPTH        = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (word_size != WORD_SIZE || address_size != ADDRESS_SIZE) begin : g_width_check
    $error("instr_fetch_unit: word_size/address_size must match fetch_pkg");
  end

  fetch_state_t            state_q, state_d;
  logic [address_size-1:0] fetch_pc_q, fetch_pc_d;
  logic [address_size-1:0] tag_q, tag_d;
  logic                    inflight_q, inflight_d;

  fetch_entry_t            push_entry;
  fetch_entry_t            head;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    issue;
  logic                    room;
  logic [CNT_W:0]          demand;

  assign pop    = !empty && bus.instr_ready;
  assign demand = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q);
  // With a pop this cycle the only way to run out of room is a full buffer
  // that is also about to receive the in-flight word.
  assign room   = pop ? !(full && inflight_q) : (demand < (CNT_W + 1)'(DEPTH));
  assign issue  = (state_q == RUN) && bus.run && !bus.redirect && room;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bus.run ? RUN : IDLE;
      RUN:     if (!bus.run) state_d = IDLE;
      IDLE:    if (bus.run)  state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (bus.redirect) state_d = state_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d = pc_next(fetch_pc_q);
      tag_d      = fetch_pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_VECTOR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = tag_q;
    push_entry.word = bus.mem_data;
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign bus.mem_address = fetch_pc_q;
  assign bus.mem_read    = issue;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? '0 : head.word;
  assign bus.instr_pc    = empty ? '0 : head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: cycle table for start-up, backpressure and redirect,
// plus hand sequences for wrap-around, run drop and reset-with-redirect.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if #(.DATA_W(WORD_SIZE), .ADDR_W(ADDRESS_SIZE)) bus ();

  instr_fetch_unit #(
    .word_size    (WORD_SIZE),
    .address_size (ADDRESS_SIZE),
    .RESET_VECTOR (8'h00),
    .DEPTH        (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 10'h100 + 10'(i);
  always @(posedge clk) bus.mem_data <= mem[bus.mem_address];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] sb_e;
  int xfer_cnt = 0;
  int read_cnt = 0;

  task automatic sb_restart(input logic [7:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 8'(k));
  endtask

  always @(negedge clk) begin
    if (bus.mem_read === 1'b1) read_cnt++;
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'(bus.instr_pc), 32'hFFFF_FFFF);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc", 32'(bus.instr_pc), 32'(sb_e));
        check("sb_word", 32'(bus.instr), 32'(10'h100 + 10'(sb_e)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ready;
    logic       redir;
    logic [7:0] rpc;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic       exp_read;
    logic [7:0] exp_addr;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] rpc,
                              input logic ev, input logic [7:0] epc,
                              input logic er, input logic [7:0] ea);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_read = er; v.exp_addr = ea;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected summary before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, r0, n;

    //              rdy rd rpc    valid pc    read addr
    vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, 0, 8'h00, 0, 8'h00, 1, 8'h00);
    vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 1, 8'h01);
    vecs[3]  = mk(1, 0, 8'h00, 1, 8'h00, 1, 8'h02);
    vecs[4]  = mk(1, 0, 8'h00, 1, 8'h01, 1, 8'h03);
    vecs[5]  = mk(0, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[6]  = mk(0, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[7]  = mk(0, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[8]  = mk(0, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[9]  = mk(0, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[10] = mk(1, 0, 8'h00, 1, 8'h02, 1, 8'h04);
    vecs[11] = mk(1, 0, 8'h00, 1, 8'h03, 1, 8'h05);
    vecs[12] = mk(1, 0, 8'h00, 1, 8'h04, 1, 8'h06);
    vecs[13] = mk(1, 0, 8'h00, 1, 8'h05, 1, 8'h07);
    vecs[14] = mk(0, 0, 8'h00, 1, 8'h06, 0, 8'h08);
    vecs[15] = mk(0, 0, 8'h00, 1, 8'h06, 0, 8'h08);
    vecs[16] = mk(0, 1, 8'h40, 1, 8'h06, 0, 8'h08);
    vecs[17] = mk(1, 0, 8'h00, 0, 8'h00, 1, 8'h40);
    vecs[18] = mk(1, 0, 8'h00, 0, 8'h00, 1, 8'h41);
    vecs[19] = mk(1, 0, 8'h00, 1, 8'h40, 1, 8'h42);
    vecs[20] = mk(1, 0, 8'h00, 1, 8'h41, 1, 8'h43);
    vecs[21] = mk(1, 0, 8'h00, 1, 8'h42, 1, 8'h44);

    rst = 1'b1;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.instr_valid), 32'd0);
    check("reset_instr", 32'(bus.instr), 32'd0);
    check("reset_instr_pc", 32'(bus.instr_pc), 32'd0);
    check("reset_mem_read", 32'(bus.mem_read), 32'd0);
    check("reset_mem_address", 32'(bus.mem_address), 32'h00);

    sb_restart(8'h00);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin
        step();
        if (vecs[i-1].redir) sb_restart(vecs[i-1].rpc);
      end
      bus.run         = 1'b1;
      bus.instr_ready = vecs[i].ready;
      bus.redirect    = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_mem_read", i), 32'(bus.mem_read), 32'(vecs[i].exp_read));
      check($sformatf("vec%0d_mem_address", i), 32'(bus.mem_address), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_instr_pc", i), 32'(bus.instr_pc), 32'(vecs[i].exp_pc));
        check($sformatf("vec%0d_instr", i), 32'(bus.instr),
              32'(10'h100 + 10'(vecs[i].exp_pc)));
      end
    end

    // Wrap-around: redirect to FE, stream must run FE, FF, 00, 01.
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hFE;
    step();
    bus.redirect = 1'b0;
    sb_restart(8'hFE);
    c0 = xfer_cnt;
    check("wrap_r1_valid", 32'(bus.instr_valid), 32'd0);
    check("wrap_r1_addr", 32'(bus.mem_address), 32'hFE);
    step();
    check("wrap_r2_valid", 32'(bus.instr_valid), 32'd0);
    check("wrap_r2_addr", 32'(bus.mem_address), 32'hFF);
    step();
    check("wrap_r3_valid", 32'(bus.instr_valid), 32'd1);
    check("wrap_r3_instr_pc", 32'(bus.instr_pc), 32'hFE);
    check("wrap_r3_addr", 32'(bus.mem_address), 32'h00);
    repeat (4) step();
    check("wrap_xfers", 32'(xfer_cnt - c0), 32'd4);

    // Run drop mid-stream: current head plus the in-flight word, then drained.
    bus.run = 1'b0;
    c0 = xfer_cnt;
    r0 = read_cnt;
    repeat (6) step();
    check("rundrop_xfers", 32'(xfer_cnt - c0), 32'd2);
    check("rundrop_reads", 32'(read_cnt - r0), 32'd0);
    check("rundrop_valid", 32'(bus.instr_valid), 32'd0);

    bus.run = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.instr_valid && n < 10);
    check("resume_latency", 32'(n), 32'd3);
    c0 = xfer_cnt;
    repeat (4) step();
    check("resume_xfers", 32'(xfer_cnt - c0), 32'd4);

    // Reset coinciding with a redirect: reset wins, fetch restarts at 0.
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h80;
    step();
    rst = 1'b0;
    bus.redirect = 1'b0;
    sb_restart(8'h00);
    check("rstredir_valid", 32'(bus.instr_valid), 32'd0);
    check("rstredir_instr", 32'(bus.instr), 32'd0);
    check("rstredir_instr_pc", 32'(bus.instr_pc), 32'd0);
    check("rstredir_mem_read", 32'(bus.mem_read), 32'd0);
    check("rstredir_mem_address", 32'(bus.mem_address), 32'h00);
    step();
    check("rstredir_c1_mem_read", 32'(bus.mem_read), 32'd1);
    check("rstredir_c1_mem_address", 32'(bus.mem_address), 32'h00);
    step();
    check("rstredir_c2_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check("rstredir_c3_valid", 32'(bus.instr_valid), 32'd1);
    check("rstredir_c3_instr_pc", 32'(bus.instr_pc), 32'h00);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the MCU core: owns the program counter, drives the read address of the program `Memory_Unit` (synchronous block RAM, 10-bit words, 8-bit address) and hands fetched words to decode. Fetched words pass through a ready/valid handshake, so decode can stall. A small buffer absorbs the memory's one-cycle read latency and keeps one-word-per-cycle throughput. Branch redirects from execute flush the buffer and any in-flight read.

## Interface
- `word_size`, default 10: instruction word width.
- `address_size`, default 8: program address width.
- `RESET_VECTOR`, default 8'h00: first fetch address after reset.
- `DEPTH`, default 2: buffer entries. Minimum 2.
- `clk`  in  1: single clock. Everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: when high, the unit may issue fetches. When low, issuing stops and the buffer drains.
- `mem_address`  out  address_size: read address to `Memory_Unit`.
- `mem_read`  out  1: a request is issued this cycle. `Memory_Unit` has no enable, so this is a debug/strobe only.
- `mem_data`  in  word_size: `Memory_Unit.data_out`. Valid one cycle after its address is presented.
- `redirect`  in  1: branch taken, one-cycle pulse.
- `redirect_pc`  in  address_size: branch target.
- `instr`  out  word_size: fetched word.
- `instr_pc`  out  address_size: address of `instr`.
- `instr_valid`  out  1: `instr` and `instr_pc` are valid.
- `instr_ready`  in  1: decode accepts. A transfer happens when `instr_valid && instr_ready`.

## Operation
- State machine `fetch_state`:
  - BOOT: one cycle after reset. No request. Goes to RUN if `run`=1, else to IDLE.
  - RUN: issues requests.
  - IDLE: issues nothing. Goes to RUN when `run`=1.
  - RUN goes to IDLE when `run`=0. A redirect in any state updates `fetch_pc` and keeps the current state.
- `fetch_pc` register drives `mem_address` directly.
- Issue rule: in RUN, issue when `occupancy + inflight - pop < DEPTH`. `pop` = transfer this cycle.
- On issue: `fetch_pc <= fetch_pc + 1`, wrapping modulo 2^address_size (8'hFF goes to 8'h00). The issued address is tagged into a one-deep in-flight register.
- Write: the cycle after an issue, `{tag, mem_data}` is written into the buffer at the clock edge. Write and pop in the same cycle are both allowed.
- Buffer: FIFO. Its head drives `instr`, `instr_pc` and `instr_valid` (= not empty). Outputs hold stable while `instr_valid && !instr_ready`.
- Redirect:
  - Buffer is cleared and the in-flight read is killed.
  - `fetch_pc <= redirect_pc`.
  - No request is issued in the redirect cycle.
  - Redirect wins over a simultaneous issue or write. A simultaneous pop still counts as consumed.
- `run` low mid-stream: the in-flight read completes and is buffered. The buffer keeps draining through the handshake.
- Reset:
  - `fetch_pc` = RESET_VECTOR, buffer empty, in-flight cleared, state BOOT.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_read`=0, `mem_address`=RESET_VECTOR.
  - Reset asserted mid-operation discards all buffered and in-flight words at the next edge.

## Timing
- Reset deasserted before cycle 0. Cycle 0 is BOOT.
- With `run`=1: first issue in cycle 1 (address RESET_VECTOR). Data arrives in cycle 2. `instr_valid` rises in cycle 3.
- Fetch latency: issue cycle N gives `instr_valid` in cycle N+2.
- Steady state with `instr_ready`=1: one instruction per cycle, no bubbles.
- Redirect in cycle R: `instr_valid`=0 in R+1, first issue of the target in R+1, target instruction valid in R+3.
- `instr_ready` low: the buffer fills to DEPTH and issue stops. No word is lost or duplicated. After ready returns, words come out in address order.

## Structure
- Package `fetch_pkg` holds:
  - `WORD_SIZE`, `ADDRESS_SIZE`, `RESET_VECTOR` constants;
  - the `fetch_state_t` enum (BOOT, RUN, IDLE);
  - the `fetch_entry_t` struct {pc, word}.
- One sub-module, `fetch_buffer`: a synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, full and empty. Flush has priority over push.
- Top level holds the PC, the in-flight tag, the FSM and the issue logic. Target is 150–250 lines in total.

## Test plan
- Reset then `run`=1, `instr_ready`=1, memory preloaded with word[i]=i+10'h100:
  - `instr_valid` first high in cycle 3 with `instr`=10'h100, `instr_pc`=0;
  - then one word per cycle, addresses 1, 2, 3…
- Backpressure: hold `instr_ready`=0 in cycles 5–9.
  - `instr` stays constant and at most DEPTH reads are outstanding.
  - After release, the `instr_pc` sequence is contiguous with no gap or repeat.
- Redirect to 8'h40 while the buffer is full:
  - `instr_valid`=0 the next cycle;
  - the next valid output has `instr_pc`=8'h40 three cycles after the redirect;
  - no stale word appears.
- Wrap-around: redirect to 8'hFE. The output sequence is `instr_pc` FE, FF, 00, 01.
- Drop `run` to 0 mid-stream:
  - exactly the in-flight word still appears, then valid falls after the buffer drains;
  - raising `run` resumes at the next sequential address.
- Assert `rst` for one cycle mid-stream, simultaneous with `redirect`:
  - outputs take reset values the next cycle;
  - fetch restarts from RESET_VECTOR, not from the redirect target.
